// File: rtl/lpc_pkg.sv
// Shared widths and FSM state encoding for the LPC autocorrelation engine.
package lpc_pkg;
  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 34;
  localparam int MAC_W    = SAMPLE_W + 1;
  localparam int LAG_W    = 4;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, MAC, OUT} state_t;
endpackage

// File: rtl/lpc_mac.sv
// Shared 17x17 signed multiplier and accumulate adder, time-multiplexed across lags.
module lpc_mac
  import lpc_pkg::*;
#(
  parameter int ACC_W = 42
) (
  input  logic signed [MAC_W-1:0] a,
  input  logic signed [MAC_W-1:0] b,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] acc_nxt
);
  logic signed [PROD_W-1:0] prod;

  assign prod    = a * b;
  assign acc_nxt = (clr ? '0 : acc_in) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
endmodule

// File: rtl/lpc_autocorr.sv
// Frame autocorrelation r[0..ORDER] over FIFO-fed 16-bit samples, lags streamed out per frame.
// Define LPC_AUTOCORR_PREEMPH_EN to pre-emphasise each captured sample before the MAC.
module lpc_autocorr
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int ORDER     = 10,
  parameter int ACC_W     = 42
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_avail,
  output logic                       req_out,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_v_in,
  output logic signed [ACC_W-1:0]    r_out,
  output logic [LAG_W-1:0]           r_lag,
  output logic                       r_v_out,
  output logic                       frame_done,
  output logic                       err_out
);
  localparam int N_W   = $clog2(FRAME_LEN) + 1;
  localparam int IDX_W = $clog2(ORDER + 1);

  state_t                  state, state_nxt;
  logic [LAG_W-1:0]        k, j, j_nxt;
  logic [N_W-1:0]          n;
  logic signed [MAC_W-1:0] hist [0:ORDER];  // hist[0] is the current sample x
  logic signed [MAC_W-1:0] y;
  logic signed [ACC_W-1:0] acc [0:ORDER];
  logic signed [ACC_W-1:0] mac_sum;
  logic                    k_last, j_last, frame_end;
  logic                    req_nxt, rv_nxt, fd_nxt;

  assign k_last    = (k == LAG_W'(ORDER));
  assign j_last    = (j == LAG_W'(ORDER));
  assign frame_end = (n == N_W'(FRAME_LEN - 1));

`ifdef LPC_AUTOCORR_PREEMPH_EN
  logic signed [SAMPLE_W-1:0] p;
  // p tracks the previous raw sample and deliberately survives frame boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          p <= '0;
    else if (state == WAIT && sample_v_in) p <= sample_in;
  assign y = MAC_W'(sample_in) - MAC_W'(p) + MAC_W'(p >>> 5);
`else
  assign y = MAC_W'(sample_in);
`endif

  lpc_mac #(.ACC_W(ACC_W)) u_mac (
    .a      (hist[0]),
    .b      (hist[k[IDX_W-1:0]]),
    .acc_in (acc[k[IDX_W-1:0]]),
    .clr    (n == '0),
    .acc_nxt(mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (src_avail) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (sample_v_in) state_nxt = MAC;
      MAC:     if (k_last) state_nxt = frame_end ? OUT : IDLE;
      OUT:     if (j_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    j_nxt   = (state == OUT) ? j + 1'b1 : '0;
    req_nxt = (state_nxt == REQ);
    rv_nxt  = (state_nxt == OUT);
    fd_nxt  = rv_nxt && (j_nxt == LAG_W'(ORDER));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_out    <= 1'b0;
      r_v_out    <= 1'b0;
      frame_done <= 1'b0;
      r_out      <= '0;
      r_lag      <= '0;
      j          <= '0;
      err_out    <= 1'b0;
    end else begin
      req_out    <= req_nxt;
      r_v_out    <= rv_nxt;
      frame_done <= fd_nxt;
      r_out      <= rv_nxt ? acc[j_nxt[IDX_W-1:0]] : '0;
      r_lag      <= rv_nxt ? j_nxt : '0;
      j          <= j_nxt;
      if (sample_v_in && state != WAIT) err_out <= 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      n <= '0;
      for (int i = 0; i <= ORDER; i++) begin
        hist[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      case (state)
        WAIT: if (sample_v_in) begin
          hist[0] <= y;
          k       <= '0;
        end
        MAC: begin
          acc[k[IDX_W-1:0]] <= mac_sum;
          k <= k_last ? '0 : k + 1'b1;
          if (k_last) begin
            for (int i = ORDER; i >= 1; i--) hist[i] <= hist[i-1];
            n <= n + 1'b1;
          end
        end
        OUT: if (j_last) begin
          n <= '0;
          for (int i = 0; i <= ORDER; i++) begin
            hist[i] <= '0;
            acc[i]  <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_lpc_autocorr.sv
// Directed bench: a small 16/2 instance for functional frames and a 256/10 instance for full scale.
module tb_lpc_autocorr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_src, a_req, a_v, a_rv, a_fd, a_err;
  logic signed [15:0] a_s;
  logic signed [41:0] a_r;
  logic [3:0] a_lag;
  logic b_src, b_req, b_v, b_rv, b_fd, b_err;
  logic signed [15:0] b_s;
  logic signed [41:0] b_r;
  logic [3:0] b_lag;

  lpc_autocorr #(.FRAME_LEN(16), .ORDER(2), .ACC_W(42)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_avail(a_src), .req_out(a_req), .sample_in(a_s),
    .sample_v_in(a_v), .r_out(a_r), .r_lag(a_lag), .r_v_out(a_rv), .frame_done(a_fd),
    .err_out(a_err));

  lpc_autocorr #(.FRAME_LEN(256), .ORDER(10), .ACC_W(42)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_avail(b_src), .req_out(b_req), .sample_in(b_s),
    .sample_v_in(b_v), .r_out(b_r), .r_lag(b_lag), .r_v_out(b_rv), .frame_done(b_fd),
    .err_out(b_err));

  int checks = 0, errors = 0;
  logic signed [41:0] a_got [0:15];
  logic signed [41:0] b_got [0:15];
  int a_nout = 0, b_nout = 0, a_nfd = 0, b_nfd = 0, a_reqs = 0;
  int a_fdlag = -1, b_fdlag = -1;

  always @(negedge clk) begin
    if (a_rv) begin a_got[a_lag] <= a_r; a_nout <= a_nout + 1; end
    if (a_fd) begin a_fdlag <= int'(a_lag); a_nfd <= a_nfd + 1; end
    if (a_req) a_reqs <= a_reqs + 1;
    if (b_rv) begin b_got[b_lag] <= b_r; b_nout <= b_nout + 1; end
    if (b_fd) begin b_fdlag <= int'(b_lag); b_nfd <= b_nfd + 1; end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise src_avail, wait for the request pulse, then answer one cycle later like the FIFO
  task automatic feed(input bit sel, input logic signed [15:0] s, output int lat);
    lat = 0;
    if (sel) b_src = 1'b1; else a_src = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? b_req : a_req) && lat < 100);
    if (lat >= 100) begin
      checks++; errors++;
      $error("FAIL req_wait: observed no req_out, expected one within 100 cycles");
    end
    if (sel) b_src = 1'b0; else a_src = 1'b0;
    @(negedge clk);
    if (sel) begin b_v = 1'b1; b_s = s; end else begin a_v = 1'b1; a_s = s; end
    @(negedge clk);
    if (sel) b_v = 1'b0; else a_v = 1'b0;
  endtask

  task automatic check_a(input string tag, input longint e0, input longint e1, input longint e2,
                         input int nout0, input int nfd0);
    chk({tag, "_r0"}, a_got[0], e0);
    chk({tag, "_r1"}, a_got[1], e1);
    chk({tag, "_r2"}, a_got[2], e2);
    chk({tag, "_burst"}, a_nout - nout0, 3);
    chk({tag, "_fd"}, a_nfd - nfd0, 1);
    chk({tag, "_fdlag"}, a_fdlag, 2);
  endtask

  int lat, n0, f0, q0;
  logic signed [15:0] s;

  initial begin
    rst_n = 1'b0;
    a_src = 0; a_v = 0; a_s = '0; b_src = 0; b_v = 0; b_s = '0;
    repeat (6) begin
      @(negedge clk);
      a_src = 1'($urandom_range(0, 1)); a_v = 1'($urandom_range(0, 1)); a_s = 16'($urandom);
      b_src = 1'($urandom_range(0, 1)); b_v = 1'($urandom_range(0, 1)); b_s = 16'($urandom);
    end
    @(negedge clk);
    chk("rst_req", a_req, 0);    chk("rst_rv", a_rv, 0);   chk("rst_fd", a_fd, 0);
    chk("rst_err", a_err, 0);    chk("rst_r", a_r, 0);     chk("rst_lag", a_lag, 0);
    chk("rst_req_b", b_req, 0);  chk("rst_rv_b", b_rv, 0); chk("rst_err_b", b_err, 0);
    chk("rst_r_b", b_r, 0);
    a_src = 0; a_v = 0; b_src = 0; b_v = 0;
    rst_n = 1'b1;

    // Full-scale negative frame on the 256/10 instance
    for (int i = 0; i < 256; i++) begin
      feed(1'b1, -16'sd32768, lat);
      if (i == 0) chk("first_req_lat", (lat >= 1 && lat <= 2), 1);
    end
    repeat (30) @(negedge clk);
    for (int k = 0; k <= 10; k++) chk($sformatf("full_r%0d", k), b_got[k], longint'(256 - k) <<< 30);
    chk("full_burst", b_nout, 11);
    chk("full_fdlag", b_fdlag, 10);

    n0 = a_nout; f0 = a_nfd;
    for (int i = 0; i < 16; i++) feed(1'b0, 16'sd100, lat);
    repeat (12) @(negedge clk);
    check_a("const", 160000, 150000, 140000, n0, f0);

    for (int rep = 0; rep < 2; rep++) begin
      n0 = a_nout; f0 = a_nfd;
      for (int i = 0; i < 16; i++) feed(1'b0, (i == 0) ? 16'sd1000 : 16'sd0, lat);
      repeat (12) @(negedge clk);
      check_a($sformatf("imp%0d", rep), 1000000, 0, 0, n0, f0);
    end

    n0 = a_nout; f0 = a_nfd;
    for (int i = 0; i < 16; i++) feed(1'b0, (i % 2 == 0) ? 16'sd200 : -16'sd200, lat);
    repeat (12) @(negedge clk);
    check_a("alt", 640000, -600000, 560000, n0, f0);

    // Stall mid-frame, with a stray sample_v_in while idle
    n0 = a_nout; f0 = a_nfd;
    for (int i = 0; i < 16; i++) begin
      feed(1'b0, 16'sd100, lat);
      if (i == 5) begin
        repeat (5) @(negedge clk);
        q0 = a_reqs;
        repeat (50) @(negedge clk);
        chk("stall_req", a_reqs - q0, 0);
        chk("pre_err", a_err, 0);
        a_v = 1'b1; a_s = 16'sd12345;
        @(negedge clk);
        a_v = 1'b0;
        @(negedge clk);
        chk("spurious_err", a_err, 1);
      end
    end
    repeat (12) @(negedge clk);
    check_a("stall", 160000, 150000, 140000, n0, f0);
    chk("err_sticky", a_err, 1);

    // Reset partway through a frame, then a clean constant frame
    for (int i = 0; i < 7; i++) feed(1'b0, 16'sd30000, lat);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_err", a_err, 0);
    chk("midrst_rv", a_rv, 0);
    rst_n = 1'b1;
    n0 = a_nout; f0 = a_nfd;
    for (int i = 0; i < 16; i++) feed(1'b0, 16'sd100, lat);
    repeat (12) @(negedge clk);
    check_a("postrst", 160000, 150000, 140000, n0, f0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpc_autocorr.md
# lpc_autocorr

Frame-based autocorrelation engine for the LPC analysis path, sitting directly downstream of the sample stream FIFO. It pulls one signed 16-bit sample at a time from the FIFO read port using a request/valid handshake. It accumulates lags r[0..ORDER] over non-overlapping frames of FRAME_LEN samples, then streams the lags out one per cycle to the Levinson-Durbin stage.

## Interface
- FRAME_LEN, 256: samples per frame; power of two, 4..1024.
- ORDER, 10: highest lag computed; 1..15.
- ACC_W, 42: accumulator and output width; must be ≥ 34 + log2(FRAME_LEN).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_avail  in  1  high when the FIFO holds at least one unread sample.
- req_out  out  1  one-cycle pulse; drives the FIFO read-advance input.
- sample_in  in  16  signed sample from the FIFO read data.
- sample_v_in  in  1  FIFO read-valid; high one cycle after req_out.
- r_out  out  ACC_W  signed lag value.
- r_lag  out  4  lag index of r_out.
- r_v_out  out  1  r_out/r_lag valid.
- frame_done  out  1  pulse coincident with the lag-ORDER output.
- err_out  out  1  sticky; sample_v_in seen outside WAIT.

## Operation
- FSM states:
  - IDLE: if src_avail, go to REQ.
  - REQ: req_out=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold until sample_v_in; capture the sample as x, set k=0, go to MAC.
  - MAC: one lag per cycle; acc[k] += x*h[k], with h[0]=x and h[k]=hist[k]. After k=ORDER:
    - shift x into hist[1].
    - n = n+1.
    - if n==FRAME_LEN go to OUT, else go to IDLE.
  - OUT: present acc[j] for j=0..ORDER, one per cycle, with r_v_out=1. frame_done=1 on j=ORDER. Then clear acc[*], hist[*] and n, and go to IDLE.
- Frame edges: hist is zero at frame start, so x[n-k]=0 for n<k. There is no overlap or carry between frames.
- Arithmetic:
  - Product is full precision, 17x17 signed → 34 bits, sign-extended to ACC_W.
  - Accumulation wraps; none occurs when the ACC_W rule holds.
- sample_v_in outside WAIT: the sample is ignored and err_out is set.
- sample_v_in never arrives in WAIT: stay in WAIT indefinitely. No timeout.
- src_avail is sampled only in IDLE; deassertion elsewhere has no effect.

## Timing
- Reset values: req_out=0, r_v_out=0, frame_done=0, err_out=0, r_out=0, r_lag=0. State IDLE; acc, hist, n and k all zero.
- Async rst_n mid-frame: the partial frame is discarded. The first frame after release is computed from fresh state.
- Per sample: ORDER+3 cycles minimum (REQ 1, WAIT ≥1, MAC ORDER+1). IDLE adds 1 cycle when src_avail is already high.
- Output burst: ORDER+1 consecutive r_v_out cycles starting the cycle after the final MAC. The next REQ is no earlier than 1 cycle after frame_done.
- All outputs are registered.

## Configuration
- LPC_AUTOCORR_PREEMPH_EN:
  - Defined: each captured sample passes through pre-emphasis y = x − p + (p>>>5), where p is the previous raw x. The result is 17-bit signed. p resets to 0 only on rst_n and persists across frames. MAC uses y.
  - Undefined: y = x, sign-extended to 17 bits. Latency is identical in both builds.

## Structure
- lpc_pkg holds:
  - SAMPLE_W=16 and PROD_W=34.
  - The FSM state enum (IDLE, REQ, WAIT, MAC, OUT).
  - The lag-index width constant.
- Sub-module lpc_mac: a 17x17 signed multiplier plus ACC_W adder with a clear input, shared across lags. It is time-multiplexed against an acc register array indexed by k.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs 0. The first req_out appears 2 cycles after release with src_avail=1.
- Constant 100, FRAME_LEN=16, ORDER=2, PREEMPH off → r0=160000, r1=150000, r2=140000. frame_done coincides with r_lag=2.
- Impulse of 1000 then 15 zeros → r0=1000000, r1=r2=0. A second identical frame gives identical output (no carry-over).
- Full scale −32768 ×256, ORDER=10 → r0=2^38 and rk=(256−k)·2^30, with no wrap.
- src_avail held low for 50 cycles mid-frame → no req_out during the hold. Results are unchanged versus a no-stall run. A spurious sample_v_in in IDLE sets err_out and leaves the results unchanged.
- rst_n pulse at sample 7 of a frame, then a constant-100 frame → same lags as the constant-100 scenario. With PREEMPH on, a constant 100 gives y=100 then y=3, so r0=10000+15·9=10135.
